// File: rtl/icap_mb_pkg.sv
// Shared definitions for the Spartan-6 MultiBoot ICAP sequencer:
// configuration command words, controller states and the ICAP byte bit-swap.
package icap_mb_pkg;

  localparam logic [15:0] DUMMY      = 16'hFFFF;
  localparam logic [15:0] SYNC0      = 16'hAA99;
  localparam logic [15:0] SYNC1      = 16'h5566;
  localparam logic [15:0] WR_GEN1    = 16'h3261;
  localparam logic [15:0] WR_GEN2    = 16'h3281;
  localparam logic [15:0] WR_GEN3    = 16'h32A1;
  localparam logic [15:0] WR_GEN4    = 16'h32C1;
  localparam logic [15:0] WR_CMD     = 16'h30A1;
  localparam logic [15:0] CMD_REBOOT = 16'h000E;
  localparam logic [15:0] NOOP       = 16'h2000;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_READY   = 2'd1,
    ST_SEQ     = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // ICAP expects each byte presented MSB-to-LSB reversed.
  function automatic logic [15:0] bitswap16(input logic [15:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_mb_rom.sv
// Combinational reboot command-word generator: maps word index k to the
// 16-bit command word (before bit-swap) and flags the final word.
module icap_mb_rom
  import icap_mb_pkg::*;
#(
  parameter logic [7:0]  SPI_OPCODE   = 8'h03,
  parameter int          WRITE_GOLDEN = 0,
  parameter logic [23:0] GOLDEN_ADDR  = 24'h000000,
  parameter int          NOOP_COUNT   = 4
) (
  input  logic [4:0]  k,
  input  logic [23:0] addr,
  output logic [15:0] word,
  output logic        last
);

  localparam int         LEN    = 9 + 4 * WRITE_GOLDEN + NOOP_COUNT;
  localparam logic [4:0] LAST_K = 5'(LEN - 1);

  logic [5:0] j;

  // Without golden programming the four GENERAL_3/4 slots are skipped.
  always_comb begin
    if ((WRITE_GOLDEN == 0) && (k >= 5'd7)) begin
      j = {1'b0, k} + 6'd4;
    end else begin
      j = {1'b0, k};
    end
  end

  always_comb begin
    case (j)
      6'd0:    word = DUMMY;
      6'd1:    word = SYNC0;
      6'd2:    word = SYNC1;
      6'd3:    word = WR_GEN1;
      6'd4:    word = addr[15:0];
      6'd5:    word = WR_GEN2;
      6'd6:    word = {SPI_OPCODE, addr[23:16]};
      6'd7:    word = WR_GEN3;
      6'd8:    word = GOLDEN_ADDR[15:0];
      6'd9:    word = WR_GEN4;
      6'd10:   word = {SPI_OPCODE, GOLDEN_ADDR[23:16]};
      6'd11:   word = WR_CMD;
      6'd12:   word = CMD_REBOOT;
      default: word = NOOP;
    endcase
  end

  assign last = (k == LAST_K);

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// Spartan-6 MultiBoot sequencer: accepts a req/sel reboot request and streams
// the IPROG command sequence for the selected flash image to an external ICAP.
module icap_multiboot_ctrl
  import icap_mb_pkg::*;
#(
  parameter int          NUM_IMAGES     = 8,
  parameter logic [23:0] IMAGE_BASE     = 24'h054000,
  parameter logic [23:0] IMAGE_STRIDE   = 24'h054000,
  parameter logic [7:0]  SPI_OPCODE     = 8'h03,
  parameter int          WRITE_GOLDEN   = 0,
  parameter logic [23:0] GOLDEN_ADDR    = 24'h000000,
  parameter int          NOOP_COUNT     = 4,
  parameter int          STARTUP_CYCLES = 15,
  localparam int         SEL_W          = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             icap_ce_n,
  output logic             icap_wr_n,
  output logic [15:0]      icap_i
);

  localparam logic [7:0] STARTUP_LAST = 8'(STARTUP_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  k, k_nx;
  logic [23:0] addr_q, addr_nx;
  logic        ready_nx, busy_nx, done_nx, err_nx, ce_n_nx, wr_n_nx;
  logic [15:0] icap_nx;
  logic [23:0] sel_addr;
  logic        sel_ok;
  logic [15:0] rom_word;
  logic        rom_last;

  // Image address wraps modulo 2^24 by construction of the 24-bit result.
  assign sel_addr = IMAGE_BASE + 24'(sel) * IMAGE_STRIDE;
  assign sel_ok   = (int'(sel) < NUM_IMAGES);

  icap_mb_rom #(
    .SPI_OPCODE   (SPI_OPCODE),
    .WRITE_GOLDEN (WRITE_GOLDEN),
    .GOLDEN_ADDR  (GOLDEN_ADDR),
    .NOOP_COUNT   (NOOP_COUNT)
  ) u_rom (
    .k    (k),
    .addr (addr_q),
    .word (rom_word),
    .last (rom_last)
  );

  // Next-state and next-output logic; outputs are registered one edge later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    k_nx     = k;
    addr_nx  = addr_q;
    ready_nx = 1'b0;
    busy_nx  = busy;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    ce_n_nx  = 1'b1;
    wr_n_nx  = 1'b1;
    icap_nx  = 16'hFFFF;
    case (state)
      ST_STARTUP: begin
        cnt_nx = cnt + 8'd1;
        if (cnt == STARTUP_LAST) begin
          state_nx = ST_READY;
          ready_nx = 1'b1;
        end else begin
          state_nx = ST_STARTUP;
        end
      end
      ST_READY: begin
        ready_nx = 1'b1;
        if (req && sel_ok) begin
          state_nx = ST_SEQ;
          addr_nx  = sel_addr;
          k_nx     = 5'd0;
          busy_nx  = 1'b1;
          ready_nx = 1'b0;
        end else if (req) begin
          err_nx = 1'b1;
        end else begin
          state_nx = ST_READY;
        end
      end
      ST_SEQ: begin
        ce_n_nx = 1'b0;
        wr_n_nx = 1'b0;
        icap_nx = bitswap16(rom_word);
        if (rom_last) begin
          state_nx = ST_FINISH;
        end else begin
          k_nx = k + 5'd1;
        end
      end
      ST_FINISH: begin
        state_nx = ST_READY;
        ready_nx = 1'b1;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = ST_STARTUP;
        cnt_nx   = 8'd0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state     <= ST_STARTUP;
      cnt       <= 8'd0;
      k         <= 5'd0;
      addr_q    <= 24'd0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      icap_ce_n <= 1'b1;
      icap_wr_n <= 1'b1;
      icap_i    <= 16'hFFFF;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      k         <= k_nx;
      addr_q    <= addr_nx;
      ready     <= ready_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      icap_ce_n <= ce_n_nx;
      icap_wr_n <= wr_n_nx;
      icap_i    <= icap_nx;
    end
  end

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// Scoreboard bench for icap_multiboot_ctrl: a default instance (a) and a
// golden-writing, 6-image, wrapping-address instance (b) share clock and reset.
module tb_icap_multiboot_ctrl;

  logic        fastclk = 1'b0;
  logic        reset   = 1'b1;
  logic        req_a   = 1'b0;
  logic        req_b   = 1'b0;
  logic [2:0]  sel_a   = 3'd0;
  logic [2:0]  sel_b   = 3'd0;
  logic        ready_a, busy_a, done_a, err_a, ce_n_a, wr_n_a;
  logic        ready_b, busy_b, done_b, err_b, ce_n_b, wr_n_b;
  logic [15:0] icap_i_a, icap_i_b;

  int          checks = 0;
  int          errors = 0;
  // Entry = {kind, icap_i}; kind 0 word, 1 done, 2 err.
  logic [17:0] qa[$];
  logic [17:0] qb[$];

  always #5 fastclk = ~fastclk;

  icap_multiboot_ctrl dut_a (
    .fastclk (fastclk), .reset (reset), .req (req_a), .sel (sel_a),
    .ready (ready_a), .busy (busy_a), .done (done_a), .err (err_a),
    .icap_ce_n (ce_n_a), .icap_wr_n (wr_n_a), .icap_i (icap_i_a)
  );

  icap_multiboot_ctrl #(
    .NUM_IMAGES (6), .IMAGE_BASE (24'hF80000), .IMAGE_STRIDE (24'h100000),
    .SPI_OPCODE (8'h0B), .WRITE_GOLDEN (1), .GOLDEN_ADDR (24'h12A5C3),
    .NOOP_COUNT (2), .STARTUP_CYCLES (5)
  ) dut_b (
    .fastclk (fastclk), .reset (reset), .req (req_b), .sel (sel_b),
    .ready (ready_b), .busy (busy_b), .done (done_b), .err (err_b),
    .icap_ce_n (ce_n_b), .icap_wr_n (wr_n_b), .icap_i (icap_i_b)
  );

  function automatic logic [15:0] sw(input logic [15:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [17:0] e);
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Expected stream built straight from the documented word list.
  task automatic push_seq(input int d, input logic [23:0] addr);
    logic [15:0] w[$];
    logic [7:0]  op;
    logic [23:0] gold;
    op   = (d == 0) ? 8'h03 : 8'h0B;
    gold = 24'h12A5C3;
    w.push_back(16'hFFFF); w.push_back(16'hAA99); w.push_back(16'h5566);
    w.push_back(16'h3261); w.push_back(addr[15:0]);
    w.push_back(16'h3281); w.push_back({op, addr[23:16]});
    if (d == 1) begin
      w.push_back(16'h32A1); w.push_back(gold[15:0]);
      w.push_back(16'h32C1); w.push_back({op, gold[23:16]});
    end
    w.push_back(16'h30A1); w.push_back(16'h000E);
    repeat ((d == 0) ? 4 : 2) w.push_back(16'h2000);
    for (int i = 0; i < w.size(); i++) push(d, {2'b00, sw(w[i])});
    push(d, {2'b01, 16'hFFFF});
  endtask

  task automatic mon(input int d, input logic ce_n, input logic wr_n, input logic [15:0] data,
                     input logic busy, input logic done, input logic err);
    logic [17:0] e;
    logic [1:0]  kind;
    int          n;
    if (!ce_n || done || err) begin
      kind = !ce_n ? 2'd0 : (done ? 2'd1 : 2'd2);
      n    = (d == 0) ? qa.size() : qb.size();
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL unexpected_output dut%0d kind=%0d icap_i=%h", d, kind, data);
      end else begin
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (e[17:16] != kind || data !== e[15:0] || wr_n !== ce_n || busy !== (kind == 2'd0)) begin
          errors++;
          $display("FAIL scoreboard dut%0d got kind=%0d icap_i=%h wr_n=%b busy=%b expected kind=%0d icap_i=%h",
                   d, kind, data, wr_n, busy, e[17:16], e[15:0]);
        end
      end
    end
  endtask

  always @(negedge fastclk) begin
    mon(0, ce_n_a, wr_n_a, icap_i_a, busy_a, done_a, err_a);
    mon(1, ce_n_b, wr_n_b, icap_i_b, busy_b, done_b, err_b);
  end

  // Called at a negedge after reset has been sampled high; releases it.
  task automatic startup_check(input bit with_err);
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge fastclk);
      chk($sformatf("startup_ready_a_%0d", i), 32'(ready_a), 32'(i == 15));
      chk($sformatf("startup_ready_b_%0d", i), 32'(ready_b), 32'(i >= 5));
      chk("startup_busy_a", 32'(busy_a), 32'd0);
      if (with_err) begin
        if (i == 6) begin push(1, {2'b10, 16'hFFFF}); req_b = 1'b1; sel_b = 3'd6; end
        if (i == 8) begin push(1, {2'b10, 16'hFFFF}); req_b = 1'b1; sel_b = 3'd7; end
        if (i == 7 || i == 9) req_b = 1'b0;
      end
    end
  endtask

  task automatic wait_ready(input int d);
    bit rdy;
    rdy = 1'b0;
    for (int c = 0; c < 40 && !rdy; c++) begin
      rdy = (d == 0) ? ready_a : ready_b;
      if (!rdy) @(negedge fastclk);
    end
    chk($sformatf("ready_timeout_dut%0d", d), 32'(rdy), 32'd1);
  endtask

  task automatic wait_done(input int d, input int exp_words);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge fastclk);
      if (d == 0) begin if (!ce_n_a) n++; seen = done_a; end
      else begin if (!ce_n_b) n++; seen = done_b; end
    end
    chk($sformatf("done_seen_dut%0d", d), 32'(seen), 32'd1);
    chk($sformatf("word_count_dut%0d", d), 32'(n), 32'(exp_words));
  endtask

  task automatic run(input int d, input logic [2:0] sel, input logic [23:0] addr);
    wait_ready(d);
    push_seq(d, addr);
    if (d == 0) begin req_a = 1'b1; sel_a = sel; end
    else begin req_b = 1'b1; sel_b = sel; end
    @(negedge fastclk);
    chk($sformatf("accept_busy_dut%0d", d), 32'((d == 0) ? busy_a : busy_b), 32'd1);
    chk($sformatf("accept_ready_dut%0d", d), 32'((d == 0) ? ready_a : ready_b), 32'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    wait_done(d, (d == 0) ? 13 : 15);
  endtask

  initial begin
    // Request held from time zero; must not be taken before startup completes.
    push_seq(0, 24'h0A8000);
    req_a = 1'b1;
    sel_a = 3'd1;
    repeat (3) @(posedge fastclk);
    @(negedge fastclk);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done_err", 32'({done_a, err_a}), 32'd0);
    chk("rst_ce_wr", 32'({ce_n_a, wr_n_a}), 32'd3);
    chk("rst_icap_i", 32'(icap_i_a), 32'h0000FFFF);
    startup_check(1'b1);
    @(negedge fastclk);
    chk("held_req_busy", 32'(busy_a), 32'd1);
    chk("held_req_ready", 32'(ready_a), 32'd0);
    req_a = 1'b0;
    sel_a = 3'd4;
    wait_done(0, 13);

    run(0, 3'd0, 24'h054000);
    run(0, 3'd7, 24'h2A0000);
    run(1, 3'd1, 24'h080000);
    run(1, 3'd5, 24'h480000);

    // Abort with reset while word 5 is on the bus.
    wait_ready(0);
    push_seq(0, 24'h0FC000);
    req_a = 1'b1;
    sel_a = 3'd2;
    @(negedge fastclk);
    req_a = 1'b0;
    repeat (6) @(negedge fastclk);
    #1;
    qa.delete();
    reset = 1'b1;
    @(negedge fastclk);
    chk("abort_ce_wr", 32'({ce_n_a, wr_n_a}), 32'd3);
    chk("abort_icap_i", 32'(icap_i_a), 32'h0000FFFF);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_ready", 32'(ready_a), 32'd0);
    startup_check(1'b0);
    run(0, 3'd2, 24'h0FC000);

    // Back-to-back: req held through done, sel changes mid-sequence.
    wait_ready(0);
    push_seq(0, 24'h150000);
    push_seq(0, 24'h24C000);
    req_a = 1'b1;
    sel_a = 3'd3;
    @(negedge fastclk);
    chk("b2b_first_busy", 32'(busy_a), 32'd1);
    sel_a = 3'd6;
    wait_done(0, 13);
    chk("b2b_ready_with_done", 32'(ready_a), 32'd1);
    @(negedge fastclk);
    chk("b2b_second_busy", 32'(busy_a), 32'd1);
    chk("b2b_second_ready", 32'(ready_a), 32'd0);
    req_a = 1'b0;
    sel_a = 3'd1;
    wait_done(0, 13);

    repeat (3) @(negedge fastclk);
    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
